nvram_autosave: RTL

Request sequencer placed directly upstream of the NVRAM backup engine. It watches CPU writes into the four battery-backed SRAM regions, along with image mounts and OSD commands. From these it generates single-cycle `load_req` / `save_req` pulses. It guarantees that requests never overlap a transfer already in progress, and it exposes per-region dirty status to the OSD.

---
 rtl/nvram_autosave.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/nvram_autosave.sv
// nvram_autosave
// Sequences load/save requests for the NVRAM backup engine. CPU writes to the
// four battery-backed SRAM regions, image mounts and OSD commands are turned
// into single-cycle load_req/save_req pulses. A new pulse is never issued while
// a transfer is still in progress, and the OSD sees which regions are dirty.
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   sram_we        one-cycle strobe per CPU write into an SRAM region
//   sram_region    region index of the write (0 ROM, 1 Ext A, 2 Ext B, 3 CMOS)
//   img_mounted    per-region mount pulses
//   osd_load       manual load request (rising edge triggers)
//   osd_save       manual save request (rising edge triggers)
//   autosave_en    enables the quiet-timer autosave
//   backup_active  OR of the engine's sd_rd / sd_wr bits
//   load_req       one-cycle load pulse
//   save_req       one-cycle save pulse
//   dirty          per-region written-since-last-transfer flags
//   busy           high while a request is being issued or awaited
module nvram_autosave #(
  parameter logic [31:0] QUIET_CYCLES  = 32'd42_954_540,
  parameter logic [31:0] SETTLE_CYCLES = 32'd4_295_454,
  parameter logic [7:0]  GUARD_CYCLES  = 8'd64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sram_we,
  input  logic [1:0] sram_region,
  input  logic [3:0] img_mounted,
  input  logic       osd_load,
  input  logic       osd_save,
  input  logic       autosave_en,
  input  logic       backup_active,
  output logic       load_req,
  output logic       save_req,
  output logic [3:0] dirty,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // The pending flags are registered, so the expiry decision has to be taken
  // one cycle before the pulse. The quiet counter therefore tops out at
  // QUIET_CYCLES-1 and the settle counter is loaded with SETTLE_CYCLES-1.
  localparam logic [31:0] QUIET_TERM  = (QUIET_CYCLES  == 32'd0) ? 32'd0 : QUIET_CYCLES  - 32'd1;
  localparam logic [31:0] SETTLE_LOAD = (SETTLE_CYCLES == 32'd0) ? 32'd0 : SETTLE_CYCLES - 32'd1;

  logic [0:0]  state_reg;
  logic [7:0]  guard_reg;
  logic [31:0] quiet_reg;
  logic [31:0] settle_reg;
  logic        settle_armed_reg;
  logic        load_pend_reg;
  logic        save_man_reg;
  logic        save_auto_reg;
  logic [3:0]  dirty_reg;
  logic        osd_load_prev_reg;
  logic        osd_save_prev_reg;

  logic        pulse;
  logic        osd_load_rise;
  logic        osd_save_rise;
  logic        quiet_fire;
  logic        settle_fire;
  logic [8:0]  guard_inc;
  logic        guard_done;
  logic [3:0]  dirty_next;

  // Pulses come straight from registered state; load always wins.
  assign load_req = (state_reg == ST_IDLE) && load_pend_reg;
  assign save_req = (state_reg == ST_IDLE) && !load_pend_reg && (save_man_reg || save_auto_reg);
  assign pulse    = load_req || save_req;
  assign busy     = (state_reg == ST_WAIT) || pulse;
  assign dirty    = dirty_reg;

  assign osd_load_rise = osd_load && !osd_load_prev_reg;
  assign osd_save_rise = osd_save && !osd_save_prev_reg;

  // Fires once, on the step into the terminal count; the counter then holds
  // there so no further autosave happens until another write restarts it.
  assign quiet_fire = autosave_en && (dirty_reg != 4'd0) && !sram_we &&
                      (QUIET_TERM != 32'd0) && (quiet_reg == QUIET_TERM - 32'd1);

  // A mount in the same cycle restarts the window instead of expiring it.
  assign settle_fire = settle_armed_reg && (img_mounted == 4'd0) && (settle_reg <= 32'd1);

  assign guard_inc  = {1'b0, guard_reg} + 9'd1;
  assign guard_done = !backup_active && (guard_inc >= {1'b0, GUARD_CYCLES});

  // A write in the pulse cycle survives the clear (set beats clear).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dirty
      assign dirty_next[gi] = (sram_we && (sram_region == 2'(gi))) ||
                              (dirty_reg[gi] && !pulse);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      guard_reg         <= 8'd0;
      quiet_reg         <= 32'd0;
      settle_reg        <= 32'd0;
      settle_armed_reg  <= 1'b0;
      load_pend_reg     <= 1'b0;
      save_man_reg      <= 1'b0;
      save_auto_reg     <= 1'b0;
      dirty_reg         <= 4'd0;
      osd_load_prev_reg <= 1'b0;
      osd_save_prev_reg <= 1'b0;
    end else begin
      osd_load_prev_reg <= osd_load;
      osd_save_prev_reg <= osd_save;
      dirty_reg         <= dirty_next;

      if (sram_we) begin
        quiet_reg <= 32'd0;
      end else if ((dirty_reg != 4'd0) && (quiet_reg < QUIET_TERM)) begin
        quiet_reg <= quiet_reg + 32'd1;
      end

      if (img_mounted != 4'd0) begin
        settle_reg       <= SETTLE_LOAD;
        settle_armed_reg <= 1'b1;
      end else if (settle_armed_reg) begin
        if (settle_fire) begin
          settle_armed_reg <= 1'b0;
        end
        if (settle_reg != 32'd0) begin
          settle_reg <= settle_reg - 32'd1;
        end
      end

      // New events take priority over the clear, so nothing arriving in a
      // pulse cycle is lost.
      if (osd_load_rise || settle_fire) begin
        load_pend_reg <= 1'b1;
      end else if (load_req) begin
        load_pend_reg <= 1'b0;
      end

      if (osd_save_rise) begin
        save_man_reg <= 1'b1;
      end else if (save_req) begin
        save_man_reg <= 1'b0;
      end

      // A load makes a pending autosave moot; a manual save survives it.
      if (quiet_fire) begin
        save_auto_reg <= 1'b1;
      end else if (pulse) begin
        save_auto_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (pulse) begin
            state_reg <= ST_WAIT;
            guard_reg <= 8'd0;
          end
        end
        default: begin
          if (backup_active) begin
            guard_reg <= 8'd0;
          end else if (guard_reg != 8'hFF) begin
            guard_reg <= guard_reg + 8'd1;
          end
          if (guard_done) begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
